// File: rtl/umai_tx_sched.sv
// Stripes an upstream 72-bit flit stream round-robin across a contiguous group of AIB TX channels.
// Latency 1 (load to o_tx_valid); a single holding buffer stalls upstream while the target channel is not ready.
module umai_tx_sched #(
    parameter int NumChannels = 6,
    parameter int ChnIdW      = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        c_enable,
    input  logic [ChnIdW-1:0]           c_first_chn_id,
    input  logic [ChnIdW-1:0]           c_last_chn_id,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [71:0]                 i_data,
    output logic [NumChannels-1:0]      o_tx_valid,
    input  logic [NumChannels-1:0]      i_tx_ready,
    output logic [NumChannels-1:0][71:0] o_tx_data,
    output logic                        o_busy,
    output logic                        o_cfg_err,
    output logic [15:0]                 o_flit_cnt
);

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_ALIGN    = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;

    localparam logic [ChnIdW:0] NumChnW = (ChnIdW+1)'(NumChannels);

    logic [1:0]          state_q, state_d;
    logic [ChnIdW-1:0]   first_q, first_d;
    logic [ChnIdW-1:0]   last_q, last_d;
    logic [ChnIdW-1:0]   ptr_q, ptr_d;
    logic [71:0]         buf_q, buf_d;
    logic                buf_vld_q, buf_vld_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                cfg_err_q, cfg_err_d;

    logic [NumChannels-1:0] sel;
    logic                   fire;
    logic                   load;
    logic                   cfg_bad;

    // One-hot decode of the pointer; ids beyond NumChannels never select a lane.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NumChannels; i++) begin
            sel[i] = (ChnIdW'(i) == ptr_q);
        end
    end

    assign fire    = buf_vld_q && |(i_tx_ready & sel);
    assign o_ready = (state_q == ST_RUN) && (!buf_vld_q || fire);
    assign load    = i_valid && o_ready;
    assign cfg_bad = (c_first_chn_id > c_last_chn_id) || ({1'b0, c_last_chn_id} >= NumChnW);

    always_comb begin
        o_tx_valid = buf_vld_q ? sel : '0;
        for (int i = 0; i < NumChannels; i++) begin
            o_tx_data[i] = sel[i] ? buf_q : 72'd0;
        end
    end

    assign o_busy     = (state_q == ST_ALIGN) || (state_q == ST_DRAIN) ||
                        ((state_q == ST_RUN) && buf_vld_q);
    assign o_cfg_err  = cfg_err_q;
    assign o_flit_cnt = cnt_q;

    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        last_d    = last_q;
        ptr_d     = ptr_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        cnt_d     = cnt_q;
        cfg_err_d = cfg_err_q;

        if (fire) begin
            ptr_d     = (ptr_q == last_q) ? first_q : ptr_q + 1'b1;
            cnt_d     = cnt_q + 16'd1;
            buf_vld_d = 1'b0;
        end
        if (load) begin
            buf_d     = i_data;
            buf_vld_d = 1'b1;
        end

        case (state_q)
            ST_DISABLED: begin
                if (c_enable) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b0;
                        state_d   = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: begin
                first_d = c_first_chn_id;
                last_d  = c_last_chn_id;
                ptr_d   = c_first_chn_id;
                cnt_d   = 16'd0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!c_enable) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                // Drain finishes regardless of c_enable; re-alignment goes through DISABLED.
                if (!buf_vld_q || fire) begin
                    state_d = ST_DISABLED;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_DISABLED;
            first_q   <= '0;
            last_q    <= '0;
            ptr_q     <= '0;
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            cnt_q     <= 16'd0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            last_q    <= last_d;
            ptr_q     <= ptr_d;
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

endmodule
